change_payout: RTL
==================

// Module: change_payout
// PURPOSE
//   Sequential coin-payout controller downstream of the vending FSM. Takes a change
//   amount in cents and drives the quarter/dime/nickel hopper solenoids one coin at a
//   time, waiting for each hopper's ejection acknowledge. Greedy largest-coin-first
//   with per-hopper inventory and jam handling; reports any unpayable shortfall.
// PARAMETERS
//   Q_INIT    16   quarters loaded at reset/refill (counter width 8 bits)
//   D_INIT    16   dimes loaded at reset/refill
//   N_INIT    16   nickels loaded at reset/refill
//   ACK_TO    64   cycles to wait for eject_ack before declaring hopper jammed
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   reset         in   1  asynchronous, active-high
//   change_valid  in   1  request strobe; accepted only when busy==0
//   change_amount in   9  change owed in cents (0..511)
//   refill        in   1  reload all counts to *_INIT, clear jam flags (IDLE only)
//   eject_q       out  1  one-cycle pulse: eject one quarter
//   eject_d       out  1  one-cycle pulse: eject one dime
//   eject_n       out  1  one-cycle pulse: eject one nickel
//   eject_ack     in   1  hopper confirms coin left (any hopper; one outstanding max)
//   busy          out  1  high from acceptance until done pulse inclusive
//   done          out  1  one-cycle pulse: payout finished
//   short_amount  out  9  cents not paid; valid with done, held until next accept
//   q_count       out  8  quarters remaining (d_count, n_count likewise, 8 bits each)
//   jam_flags     out  3  {q,d,n} hopper marked jammed
// BEHAVIOUR
//   Reset: state IDLE; all eject_*, busy, done = 0; short_amount = 0;
//     counts = *_INIT; jam_flags = 0; remaining = 0.
//   States: IDLE -> SELECT -> EJECT -> WAIT_ACK -> SELECT ... -> DONE -> IDLE.
//   IDLE: change_valid & !busy -> latch remaining = change_amount, busy=1, go SELECT.
//     change_valid while busy is ignored (no queueing). refill applies in IDLE only;
//     refill and change_valid same cycle: refill takes effect, request also accepted.
//   SELECT (1 cycle): pick coin = largest of 25/10/5 with value<=remaining,
//     count!=0, jam flag clear. Found -> EJECT. None -> DONE with
//     short_amount = remaining (covers remaining<5, non-multiples of 5, exhaustion).
//     remaining==0 -> DONE, short_amount=0.
//   EJECT (1 cycle): assert exactly one eject_* for that cycle; start timeout counter.
//   WAIT_ACK: eject_ack -> remaining -= coin value, count -= 1, go SELECT.
//     Counter reaching ACK_TO with no ack -> set jam flag for that hopper, count and
//     remaining unchanged, go SELECT (falls back to smaller coins).
//     eject_ack outside WAIT_ACK is ignored.
//   DONE (1 cycle): done=1, busy still 1; next cycle IDLE, busy=0.
//   Latency: zero change -> done 2 cycles after accept. Each coin costs
//     SELECT+EJECT+ack wait (min 3 cycles with ack on the cycle after the pulse).
//   Arithmetic: remaining is 9-bit unsigned, never underflows (coin<=remaining checked);
//     counts never decrement below 0. Jam flags persist until refill or reset.
//   Reset mid-payout: immediate return to reset values, outstanding ejection forgotten.
// TESTING
//   Reset, change 65, ack 1 cycle after each pulse -> pulses Q,Q,D,N; done;
//     short=0; q_count=14, d_count=15, n_count=15.
//   Q_INIT=1, change 50 -> Q,D,D,N; short=0; q_count=0.
//   Change 7 -> one N then done with short_amount=2.
//   Change 25, never ack quarter -> after ACK_TO cycles jam_flags=3'b100,
//     then D,D,N paid, short=0; refill clears jam_flags.
//   change_valid pulsed again while busy -> ignored; reset asserted during WAIT_ACK
//     -> all outputs at reset values next edge.
//   Change 0 -> done exactly 2 cycles after accept, no eject pulses.

Source files
------------

// File: rtl/change_payout_if.sv
// Purpose: groups the payout request, hopper and status signals of
//          change_payout into one bundle.
// Ports (signals):
//   change_valid, change_amount[8:0], refill  - requester -> payout controller
//   eject_q, eject_d, eject_n                 - payout controller -> hopper solenoids
//   eject_ack                                 - hoppers -> payout controller
//   busy, done, short_amount[8:0]             - payout status
//   q_count, d_count, n_count[7:0], jam_flags - hopper inventory and jam status
// Modports: master = requester/hopper side, slave = payout controller.
interface change_payout_if;
  logic       change_valid;
  logic [8:0] change_amount;
  logic       refill;
  logic       eject_q;
  logic       eject_d;
  logic       eject_n;
  logic       eject_ack;
  logic       busy;
  logic       done;
  logic [8:0] short_amount;
  logic [7:0] q_count;
  logic [7:0] d_count;
  logic [7:0] n_count;
  logic [2:0] jam_flags;

  modport master (
    output change_valid, change_amount, refill, eject_ack,
    input  eject_q, eject_d, eject_n, busy, done, short_amount,
           q_count, d_count, n_count, jam_flags
  );

  modport slave (
    input  change_valid, change_amount, refill, eject_ack,
    output eject_q, eject_d, eject_n, busy, done, short_amount,
           q_count, d_count, n_count, jam_flags
  );
endinterface

// File: rtl/change_payout.sv
// Purpose: sequential coin-payout controller. Pays a change amount greedily
//          (quarter, dime, nickel) one coin at a time, waiting for each hopper's
//          eject acknowledge, tracking per-hopper inventory and jams, and
//          reporting any amount that could not be paid.
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - asynchronous, active-high
//   bus   - change_payout_if.slave (request, hopper pulses/ack, status, counts)
module change_payout #(
  parameter int Q_INIT = 16,
  parameter int D_INIT = 16,
  parameter int N_INIT = 16,
  parameter int ACK_TO = 64
) (
  input  logic            clk,
  input  logic            reset,
  change_payout_if.slave  bus
);

  localparam int TW = $clog2(ACK_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_t;

  state_t        state_q, state_d;
  coin_t         coin_q, coin_d;
  logic [8:0]    remaining_q, remaining_d;
  logic [8:0]    short_q, short_d;
  logic [7:0]    q_cnt_q, q_cnt_d;
  logic [7:0]    d_cnt_q, d_cnt_d;
  logic [7:0]    n_cnt_q, n_cnt_d;
  logic [2:0]    jam_q, jam_d;
  logic [TW-1:0] timer_q, timer_d;

  function automatic logic [8:0] coin_value(input coin_t c);
    case (c)
      COIN_Q:  return 9'd25;
      COIN_D:  return 9'd10;
      default: return 9'd5;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      coin_q      <= COIN_Q;
      remaining_q <= '0;
      short_q     <= '0;
      q_cnt_q     <= 8'(Q_INIT);
      d_cnt_q     <= 8'(D_INIT);
      n_cnt_q     <= 8'(N_INIT);
      jam_q       <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      q_cnt_q     <= q_cnt_d;
      d_cnt_q     <= d_cnt_d;
      n_cnt_q     <= n_cnt_d;
      jam_q       <= jam_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    q_cnt_d     = q_cnt_q;
    d_cnt_d     = d_cnt_q;
    n_cnt_d     = n_cnt_q;
    jam_d       = jam_q;
    timer_d     = timer_q;

    case (state_q)
      S_IDLE: begin
        // Refill and a new request in the same cycle both take effect.
        if (bus.refill) begin
          q_cnt_d = 8'(Q_INIT);
          d_cnt_d = 8'(D_INIT);
          n_cnt_d = 8'(N_INIT);
          jam_d   = '0;
        end
        if (bus.change_valid) begin
          remaining_d = bus.change_amount;
          short_d     = '0;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        // Checking coin <= remaining keeps the remaining amount from underflowing;
        // checking count != 0 keeps the counters from wrapping.
        if (remaining_q >= 9'd25 && q_cnt_q != 8'd0 && !jam_q[2]) begin
          coin_d  = COIN_Q;
          state_d = S_EJECT;
        end else if (remaining_q >= 9'd10 && d_cnt_q != 8'd0 && !jam_q[1]) begin
          coin_d  = COIN_D;
          state_d = S_EJECT;
        end else if (remaining_q >= 9'd5 && n_cnt_q != 8'd0 && !jam_q[0]) begin
          coin_d  = COIN_N;
          state_d = S_EJECT;
        end else begin
          short_d = remaining_q;
          state_d = S_DONE;
        end
      end

      S_EJECT: begin
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        // An ack arriving on the last timeout cycle still counts as paid.
        if (bus.eject_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          case (coin_q)
            COIN_Q:  q_cnt_d = q_cnt_q - 8'd1;
            COIN_D:  d_cnt_d = d_cnt_q - 8'd1;
            default: n_cnt_d = n_cnt_q - 8'd1;
          endcase
          state_d = S_SELECT;
        end else if (timer_q == TW'(ACK_TO - 1)) begin
          case (coin_q)
            COIN_Q:  jam_d[2] = 1'b1;
            COIN_D:  jam_d[1] = 1'b1;
            default: jam_d[0] = 1'b1;
          endcase
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.eject_q      = (state_q == S_EJECT) && (coin_q == COIN_Q);
  assign bus.eject_d      = (state_q == S_EJECT) && (coin_q == COIN_D);
  assign bus.eject_n      = (state_q == S_EJECT) && (coin_q == COIN_N);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.short_amount = short_q;
  assign bus.q_count      = q_cnt_q;
  assign bus.d_count      = d_cnt_q;
  assign bus.n_count      = n_cnt_q;
  assign bus.jam_flags    = jam_q;

endmodule
